// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: operation encoding, FSM states and
// small decode helpers used by the top and the alignment logic.
package lsu_pkg;

  // Low three bits follow the load funct3 encoding; bit 3 marks a store.
  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LH  = 4'b0001,
    OP_LW  = 4'b0010,
    OP_LBU = 4'b0100,
    OP_LHU = 4'b0101,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } lsu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RESP
  } lsu_state_t;

  function automatic logic is_store(lsu_op_t op);
    return op[3];
  endfunction

  // Size is encoded in op[1:0]: 00 byte, 01 halfword, 10 word.
  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] off);
    case (op[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
// The master modport is the unit itself; slave is the core/memory side.
interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  lsu_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_miss;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_miss,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_miss,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
           mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: extracts/extends sub-word load data and merges
// sub-word store data into a previously read memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rword_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    load_o   = rword_i;
    merge_o  = rword_i;
    case (op_i)
      OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_o = {24'h000000, byte_sel};
      OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_o = {16'h0000, half_sel};
      OP_SB:   merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      OP_SH: begin
        if (off_i[1]) merge_o[31:16] = wdata_i;
        else          merge_o[15:0]  = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, stalls on memory miss, sub-word
// loads are extracted and extended, sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic clk,
  input  logic rstn,
  load_store_unit_if.master bus
);

  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_data;

  lsu_align u_align (
    .op_i    (op_q),
    .off_i   (off_q),
    .rword_i (bus.mem_rdata),
    .wdata_i (wdata_q),
    .load_o  (load_data),
    .merge_o (merged_data)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d       = bus.req_op;
          off_d      = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata[15:0];
          err_d      = is_misaligned(bus.req_op, bus.req_addr[1:0]);
          mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
          if (err_d) begin
            state_d = ST_RESP;
          end else if (bus.req_op == OP_SW) begin
            mem_wdata_d = bus.req_wdata;
            state_d     = ST_WR_ISSUE;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (!bus.mem_miss) begin
          if (is_store(op_q)) begin
            mem_wdata_d = merged_data;
            state_d     = ST_WR_ISSUE;
          end else begin
            resp_rdata_d = load_data;
            state_d      = ST_RESP;
          end
        end
      end
      ST_WR_ISSUE: state_d = ST_WR_WAIT;
      ST_WR_WAIT:  if (!bus.mem_miss) state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Strobes and response flags are registered copies of the next state.
    resp_valid_d = (state_d == ST_RESP);
    resp_err_d   = (state_d == ST_RESP) && err_d;
    mem_re_d     = (state_d == ST_RD_ISSUE);
    mem_we_d     = (state_d == ST_WR_ISSUE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LW;
      off_q        <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.stall      = (state_q != ST_IDLE) || resp_valid_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word memory model
// that returns registered read data and a programmable miss window.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rstn;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: poke port for preloading, registered read data, and a
  // miss window of missCfg cycles starting the cycle after each strobe.
  logic [31:0] memArr [0:255];
  int          missCfg;
  int          missCnt = 0;
  logic        pokeEn;
  logic [31:0] pokeAddr;
  logic [31:0] pokeData;

  function automatic int curMiss();
    return (bus.mem_re || bus.mem_we) ? missCfg : missCnt;
  endfunction

  always @(posedge clk) begin
    if (pokeEn) memArr[pokeAddr[9:2]] <= pokeData;
    else if (bus.mem_we) memArr[bus.mem_addr[9:2]] <= bus.mem_wdata;
    bus.mem_rdata <= memArr[bus.mem_addr[9:2]];
    bus.mem_miss  <= (curMiss() > 0);
    missCnt       <= (curMiss() > 0) ? curMiss() - 1 : 0;
  end

  // Strobe / response monitor, sampled away from the active edge.
  int          reCount;
  int          weCount;
  int          respCount;
  int          overlapCount = 0;
  logic [31:0] lastWdata;

  always @(negedge clk) begin
    if (bus.mem_re) reCount++;
    if (bus.mem_we) begin
      weCount++;
      lastWdata = bus.mem_wdata;
    end
    if (bus.mem_re && bus.mem_we) overlapCount++;
    if (bus.resp_valid) respCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic pokeWord(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pokeEn   = 1'b1;
    pokeAddr = addr;
    pokeData = data;
    @(negedge clk);
    pokeEn   = 1'b0;
  endtask

  logic [31:0] lastRdata;
  logic        lastErr;
  int          lastLatency;
  logic        stallOk;
  logic        addrOk;

  task automatic applyStimulus(input string tag, input lsu_op_t op, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int   n;
    logic done;
    @(negedge clk);
    reCount       = 0;
    weCount       = 0;
    stallOk       = 1'b1;
    addrOk        = 1'b1;
    lastRdata     = 'x;
    lastErr       = 1'bx;
    lastLatency   = -1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n    = 1;
    done = 1'b0;
    while (!done && n <= 60) begin
      if (!bus.stall) stallOk = 1'b0;
      if (bus.mem_addr !== {addr[31:2], 2'b00}) addrOk = 1'b0;
      if (bus.resp_valid) begin
        done        = 1'b1;
        lastRdata   = bus.resp_rdata;
        lastErr     = bus.resp_err;
        lastLatency = n;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput({tag, ".respSeen"}, 32'(done), 32'd1);
  endtask

  task automatic checkResp(input string tag, input logic [31:0] expData, input int expLat,
                           input int expRe, input int expWe, input logic expErr);
    checkOutput({tag, ".rdata"}, lastRdata, expData);
    checkOutput({tag, ".latency"}, 32'(lastLatency), 32'(expLat));
    checkOutput({tag, ".reCount"}, 32'(reCount), 32'(expRe));
    checkOutput({tag, ".weCount"}, 32'(weCount), 32'(expWe));
    checkOutput({tag, ".err"}, 32'(lastErr), 32'(expErr));
    checkOutput({tag, ".stallHeld"}, 32'(stallOk), 32'd1);
    if (!expErr) checkOutput({tag, ".addrHeld"}, 32'(addrOk), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LW;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    pokeEn        = 1'b0;
    pokeAddr      = '0;
    pokeData      = '0;
    missCfg       = 0;
    respCount     = 0;

    pokeWord(32'h100, 32'hDEADBEEF);
    pokeWord(32'h300, 32'h80FF1234);
    pokeWord(32'h140, 32'h11223344);

    @(negedge clk);
    checkOutput("rst.req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst.resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst.resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst.mem_re", 32'(bus.mem_re), 32'd0);
    checkOutput("rst.mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst.mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst.mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst.stall", 32'(bus.stall), 32'd0);
    rstn = 1'b1;

    applyStimulus("lw100", OP_LW, 32'h100, 32'h0);
    checkResp("lw100", 32'hDEADBEEF, 3, 1, 0, 1'b0);

    missCfg = 2;
    applyStimulus("lwMiss2", OP_LW, 32'h100, 32'h0);
    checkResp("lwMiss2", 32'hDEADBEEF, 5, 1, 0, 1'b0);
    missCfg = 0;

    applyStimulus("lb303", OP_LB, 32'h303, 32'h0);
    checkResp("lb303", 32'hFFFFFF80, 3, 1, 0, 1'b0);
    applyStimulus("lbu303", OP_LBU, 32'h303, 32'h0);
    checkResp("lbu303", 32'h00000080, 3, 1, 0, 1'b0);
    applyStimulus("lhu302", OP_LHU, 32'h302, 32'h0);
    checkResp("lhu302", 32'h000080FF, 3, 1, 0, 1'b0);
    applyStimulus("lh302", OP_LH, 32'h302, 32'h0);
    checkResp("lh302", 32'hFFFF80FF, 3, 1, 0, 1'b0);
    applyStimulus("lb300", OP_LB, 32'h300, 32'h0);
    checkResp("lb300", 32'h00000034, 3, 1, 0, 1'b0);

    applyStimulus("sb141", OP_SB, 32'h141, 32'h000000AA);
    checkResp("sb141", 32'h0, 5, 1, 1, 1'b0);
    checkOutput("sb141.mem_wdata", lastWdata, 32'h1122AA44);
    applyStimulus("lw140a", OP_LW, 32'h140, 32'h0);
    checkResp("lw140a", 32'h1122AA44, 3, 1, 0, 1'b0);

    applyStimulus("sh142", OP_SH, 32'h142, 32'h1234BEEF);
    checkResp("sh142", 32'h0, 5, 1, 1, 1'b0);
    checkOutput("sh142.mem_wdata", lastWdata, 32'hBEEFAA44);
    applyStimulus("lw140b", OP_LW, 32'h140, 32'h0);
    checkResp("lw140b", 32'hBEEFAA44, 3, 1, 0, 1'b0);

    missCfg = 10;
    applyStimulus("swMiss10", OP_SW, 32'h180, 32'hCAFEF00D);
    checkResp("swMiss10", 32'h0, 13, 0, 1, 1'b0);
    checkOutput("swMiss10.mem_wdata", lastWdata, 32'hCAFEF00D);
    missCfg = 0;
    applyStimulus("lw180", OP_LW, 32'h180, 32'h0);
    checkResp("lw180", 32'hCAFEF00D, 3, 1, 0, 1'b0);

    applyStimulus("lh201", OP_LH, 32'h201, 32'h0);
    checkResp("lh201", 32'h0, 1, 0, 0, 1'b1);
    applyStimulus("sw202", OP_SW, 32'h202, 32'h55555555);
    checkResp("sw202", 32'h0, 1, 0, 0, 1'b1);

    // Reset while an SH is parked in RD_WAIT behind a long miss.
    missCfg = 20;
    @(negedge clk);
    respCount     = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SH;
    bus.req_addr  = 32'h240;
    bus.req_wdata = 32'h00005555;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("rstMid.mem_re", 32'(bus.mem_re), 32'd0);
    checkOutput("rstMid.mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rstMid.req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rstMid.resp_valid", 32'(bus.resp_valid), 32'd0);
    missCfg = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rstMid.respCount", 32'(respCount), 32'd0);
    checkOutput("rstMid.readyAfter", 32'(bus.req_ready), 32'd1);

    applyStimulus("lwAfterRst", OP_LW, 32'h100, 32'h0);
    checkResp("lwAfterRst", 32'hDEADBEEF, 3, 1, 0, 1'b0);

    checkOutput("reWeOverlap", 32'(overlapCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
